level_qualifier: RTL and testbench

LEVEL_QUALIFIER -- requirements
Module: level_qualifier

---
 rtl/level_qualifier.sv | 147 ++++++++++++++
 tb/tb_level_qualifier.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/level_qualifier.sv
// Per-channel level qualifier: two-flop synchronizer, hold-time qualification, rise/fall pulses.
// Optional release filtering is enabled by defining LEVEL_QUALIFIER_RELEASE_FILTER_EN.
module level_qualifier #(
  parameter int CHANNELS       = 4,
  parameter int HOLD_CYCLES    = 2500,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] ready,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                all_ready
);

`ifdef LEVEL_QUALIFIER_RELEASE_FILTER_EN
  localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int REL_TERM_I = RELEASE_CYCLES - 1;
`else
  // Release length has no effect when release is immediate.
  localparam int CNT_MAX = HOLD_CYCLES + (RELEASE_CYCLES * 0);
`endif
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef LEVEL_QUALIFIER_RELEASE_FILTER_EN
  localparam logic [CNT_W-1:0] REL_TERM  = CNT_W'(REL_TERM_I);
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_ready_nxt;
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;

  // Two-flop synchronizer; only r_sync2 is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise;
    logic             w_fall;

    // Channel state and shared hold/release counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next-state, counter and edge-pulse decode.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_sync2[i]) begin
            if (r_cnt >= HOLD_TERM) begin
              w_state_nxt = ST_READY;
              w_cnt_nxt   = '0;
              w_rise      = 1'b1;
            end else if (r_cnt != CNT_SAT) begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
              w_cnt_nxt = r_cnt;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        ST_READY: begin
`ifdef LEVEL_QUALIFIER_RELEASE_FILTER_EN
          if (!r_sync2[i]) begin
            if (r_cnt >= REL_TERM) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
              w_fall      = 1'b1;
            end else if (r_cnt != CNT_SAT) begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
              w_cnt_nxt = r_cnt;
            end
          end else begin
            w_cnt_nxt = '0;
          end
`else
          if (!r_sync2[i]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_fall      = 1'b1;
          end else begin
            w_cnt_nxt = '0;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_ready_nxt[i] = (w_state_nxt == ST_READY);
    assign w_rise_nxt[i]  = w_rise;
    assign w_fall_nxt[i]  = w_fall;
  end

  // Registered outputs, aligned with the state transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= '0;
      rise      <= '0;
      fall      <= '0;
      all_ready <= 1'b0;
    end else begin
      ready     <= w_ready_nxt;
      rise      <= w_rise_nxt;
      fall      <= w_fall_nxt;
      all_ready <= &w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_level_qualifier.sv
// Directed self-checking bench for level_qualifier (CHANNELS=2, HOLD_CYCLES=8, RELEASE_CYCLES=4).
module tb_level_qualifier;

  logic       clk;
  logic       rst;
  logic [1:0] sig_in;
  logic [1:0] ready;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       all_ready;

  int cyc   = 0;
  int base  = 0;
  int total = 0;
  int bad   = 0;

  level_qualifier #(
    .CHANNELS      (2),
    .HOLD_CYCLES   (8),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .ready    (ready),
    .rise     (rise),
    .fall     (fall),
    .all_ready(all_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the falling edge that follows relative edge e.
  task automatic wait_rel(input int e);
    if (cyc - base > e) begin
      bad++;
      $display("FAIL sched: rel=%0d already past %0d", cyc - base, e);
    end
    while (cyc - base < e) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge clk);
    rst = 1'b1;
    sig_in = v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sig_in = 2'b11;
    repeat (3) @(negedge clk);
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", ready); end
    total++; if (rise !== 2'b00) begin bad++; $display("FAIL rst_rise: got %b want 00", rise); end
    total++; if (fall !== 2'b00) begin bad++; $display("FAIL rst_fall: got %b want 00", fall); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL rst_all: got %b want 0", all_ready); end
  endtask

  task automatic test_hold;
    do_reset(2'b00);
    wait_rel(9);
    sig_in = 2'b01;
    for (int e = 10; e <= 18; e++) begin
      wait_rel(e);
      total++; if (ready !== 2'b00 || rise !== 2'b00) begin bad++; $display("FAIL hold_early@%0d: ready=%b rise=%b want 00/00", e, ready, rise); end
    end
    wait_rel(19);
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL hold_ready: got %b want 01", ready); end
    total++; if (rise !== 2'b01) begin bad++; $display("FAIL hold_rise: got %b want 01", rise); end
    total++; if (fall !== 2'b00) begin bad++; $display("FAIL hold_fall: got %b want 00", fall); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL hold_all: got %b want 0", all_ready); end
    wait_rel(20);
    total++; if (rise !== 2'b00 || ready !== 2'b01) begin bad++; $display("FAIL hold_after: rise=%b ready=%b want 00/01", rise, ready); end
  endtask

  task automatic test_glitch;
    do_reset(2'b00);
    wait_rel(21);
    sig_in = 2'b01;
    wait_rel(28);
    sig_in = 2'b00;
    wait_rel(29);
    sig_in = 2'b01;
    for (int e = 30; e <= 38; e++) begin
      wait_rel(e);
      total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL glitch_early@%0d: ready0=%b want 0", e, ready[0]); end
    end
    wait_rel(39);
    total++; if (ready !== 2'b01 || rise !== 2'b01) begin bad++; $display("FAIL glitch_ready: ready=%b rise=%b want 01/01", ready, rise); end
  endtask

`ifdef LEVEL_QUALIFIER_RELEASE_FILTER_EN
  task automatic test_release_filter;
    do_reset(2'b00);
    wait_rel(9);
    sig_in = 2'b01;
    wait_rel(19);
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL flt_ready: got %b want 01", ready); end
    wait_rel(39);
    sig_in = 2'b00;
    for (int e = 40; e <= 54; e++) begin
      wait_rel(e);
      total++; if (ready !== 2'b01 || fall !== 2'b00) begin bad++; $display("FAIL flt_hold@%0d: ready=%b fall=%b want 01/00", e, ready, fall); end
      if (e == 42) sig_in = 2'b01;
      if (e == 49) sig_in = 2'b00;
    end
    wait_rel(55);
    total++; if (ready !== 2'b00 || fall !== 2'b01) begin bad++; $display("FAIL flt_drop: ready=%b fall=%b want 00/01", ready, fall); end
    total++; if (rise !== 2'b00) begin bad++; $display("FAIL flt_rise: got %b want 00", rise); end
    wait_rel(56);
    total++; if (fall !== 2'b00) begin bad++; $display("FAIL flt_fall_once: got %b want 00", fall); end
  endtask
`else
  task automatic test_release_fast;
    do_reset(2'b00);
    wait_rel(9);
    sig_in = 2'b01;
    wait_rel(19);
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL rel_ready: got %b want 01", ready); end
    wait_rel(49);
    sig_in = 2'b00;
    wait_rel(50);
    sig_in = 2'b01;
    wait_rel(51);
    total++; if (ready !== 2'b01 || fall !== 2'b00) begin bad++; $display("FAIL rel_pre: ready=%b fall=%b want 01/00", ready, fall); end
    wait_rel(52);
    total++; if (ready !== 2'b00 || fall !== 2'b01) begin bad++; $display("FAIL rel_drop: ready=%b fall=%b want 00/01", ready, fall); end
    total++; if (rise !== 2'b00) begin bad++; $display("FAIL rel_rise: got %b want 00", rise); end
    for (int e = 53; e <= 59; e++) begin
      wait_rel(e);
      total++; if (ready !== 2'b00 || fall !== 2'b00) begin bad++; $display("FAIL rel_requal@%0d: ready=%b fall=%b want 00/00", e, ready, fall); end
    end
    wait_rel(60);
    total++; if (ready !== 2'b01 || rise !== 2'b01) begin bad++; $display("FAIL rel_back: ready=%b rise=%b want 01/01", ready, rise); end
  endtask
`endif

  task automatic test_reset_mid;
    do_reset(2'b00);
    wait_rel(4);
    sig_in = 2'b11;
    wait_rel(14);
    total++; if (ready !== 2'b11 || rise !== 2'b11 || all_ready !== 1'b1) begin bad++; $display("FAIL mid_both: ready=%b rise=%b all=%b want 11/11/1", ready, rise, all_ready); end
    wait_rel(16);
    #2;
    rst = 1'b1;
    #1;
    total++; if (ready !== 2'b00 || all_ready !== 1'b0) begin bad++; $display("FAIL mid_async: ready=%b all=%b want 00/0", ready, all_ready); end
    total++; if (fall !== 2'b00 || rise !== 2'b00) begin bad++; $display("FAIL mid_pulse: fall=%b rise=%b want 00/00", fall, rise); end
    repeat (2) begin
      @(negedge clk);
      total++; if (ready !== 2'b00 || fall !== 2'b00) begin bad++; $display("FAIL mid_held: ready=%b fall=%b want 00/00", ready, fall); end
    end
    rst = 1'b0;
    base = cyc;
    for (int e = 1; e <= 9; e++) begin
      wait_rel(e);
      total++; if (ready !== 2'b00 || all_ready !== 1'b0) begin bad++; $display("FAIL mid_requal@%0d: ready=%b all=%b want 00/0", e, ready, all_ready); end
    end
    wait_rel(10);
    total++; if (ready !== 2'b11 || rise !== 2'b11 || all_ready !== 1'b1) begin bad++; $display("FAIL mid_back: ready=%b rise=%b all=%b want 11/11/1", ready, rise, all_ready); end
    wait_rel(11);
    total++; if (rise !== 2'b00 || ready !== 2'b11) begin bad++; $display("FAIL mid_after: rise=%b ready=%b want 00/11", rise, ready); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    sig_in = 2'b00;
    test_reset;
    test_hold;
    test_glitch;
`ifdef LEVEL_QUALIFIER_RELEASE_FILTER_EN
    test_release_filter;
`else
    test_release_fast;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
